// File: rtl/fp_add_seq.sv
// Sequential single-precision adder/subtractor. Operations pass through ALIGN, ADD and NORM
// states. NORM runs one cycle per left shift. Rounding is by truncation. Denormals and NaN are not supported.
module fp_add_seq #(
  parameter int SIGNI       = 23,
  parameter int EXPO_LENGTH = 7
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [SIGNI+EXPO_LENGTH+1:0] para1,
  input  logic [SIGNI+EXPO_LENGTH+1:0] para2,
  input  logic                         op,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [SIGNI+EXPO_LENGTH+1:0] out,
  output logic                         under_overflow,
  output logic [2:0]                   dbg_state
);

  localparam int DW = SIGNI + EXPO_LENGTH + 2;
  localparam int EW = EXPO_LENGTH + 1;
  localparam int MW = SIGNI + 1;
  localparam logic [EW-1:0] EXP_MAX     = '1;
  localparam logic [EW-1:0] EXP_ONE     = EW'(1);
  localparam logic [EW-1:0] SHIFT_LIMIT = EW'(MW + 1);

  // Handshake: a transfer happens on a rising edge where valid && ready; in_ready is high
  // only in IDLE, and out_valid holds high with a stable result until out_ready is seen.
  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_DONE} state_t;

  state_t          r_state, w_next;
  logic [DW-1:0]   r_a, r_b;
  logic            r_sign, r_eff_sub;
  logic [EW-1:0]   r_exp;
  logic [MW-1:0]   r_sig_big, r_sig_small;
  logic [MW:0]     r_sum;
  logic [DW-1:0]   r_out;
  logic            r_flag;

  logic [EW-1:0]   w_a_exp, w_b_exp, w_exp_big, w_exp_small, w_diff;
  logic [MW-1:0]   w_a_sig, w_b_sig, w_sig_big, w_sig_small, w_shifted;
  logic            w_a_big, w_sign_big, w_sign_small, w_any_inf, w_inf_sign;
  logic [MW:0]     w_add, w_sum_shl;
  logic [EW-1:0]   w_exp_inc, w_exp_dec;
  logic            w_norm_done, w_norm_flag;
  logic [DW-1:0]   w_norm_out;

  assign w_a_exp = r_a[DW-2:SIGNI];
  assign w_b_exp = r_b[DW-2:SIGNI];
  // An exponent of zero means the operand is zero; its fraction field is ignored.
  assign w_a_sig = (w_a_exp != '0) ? {1'b1, r_a[SIGNI-1:0]} : '0;
  assign w_b_sig = (w_b_exp != '0) ? {1'b1, r_b[SIGNI-1:0]} : '0;

  assign w_any_inf  = (w_a_exp == EXP_MAX) || (w_b_exp == EXP_MAX);
  assign w_inf_sign = (w_a_exp == EXP_MAX) ? r_a[DW-1] : r_b[DW-1];

  assign w_a_big      = (r_a[DW-2:0] >= r_b[DW-2:0]);
  assign w_exp_big    = w_a_big ? w_a_exp : w_b_exp;
  assign w_exp_small  = w_a_big ? w_b_exp : w_a_exp;
  assign w_sig_big    = w_a_big ? w_a_sig : w_b_sig;
  assign w_sig_small  = w_a_big ? w_b_sig : w_a_sig;
  assign w_sign_big   = w_a_big ? r_a[DW-1] : r_b[DW-1];
  assign w_sign_small = w_a_big ? r_b[DW-1] : r_a[DW-1];
  assign w_diff       = w_exp_big - w_exp_small;
  assign w_shifted    = (w_diff >= SHIFT_LIMIT) ? '0 : (w_sig_small >> w_diff);

  // Operands are ordered by magnitude, so the difference can never go negative.
  assign w_add = r_eff_sub ? ({1'b0, r_sig_big} - {1'b0, r_sig_small})
                           : ({1'b0, r_sig_big} + {1'b0, r_sig_small});

  assign w_exp_inc = r_exp + EXP_ONE;
  assign w_exp_dec = r_exp - EXP_ONE;
  assign w_sum_shl = {r_sum[MW-1:0], 1'b0};

  always_comb begin
    w_norm_done = 1'b1;
    w_norm_flag = 1'b0;
    w_norm_out  = '0;
    if (r_sum == '0) begin
      w_norm_flag = 1'b0;
    end else if (r_sum[MW]) begin
      if (w_exp_inc == EXP_MAX) begin
        w_norm_out  = {r_sign, EXP_MAX, {SIGNI{1'b0}}};
        w_norm_flag = 1'b1;
      end else begin
        w_norm_out = {r_sign, w_exp_inc, r_sum[MW-1:1]};
      end
    end else if (r_sum[MW-1]) begin
      w_norm_out = {r_sign, r_exp, r_sum[SIGNI-1:0]};
    end else if (r_exp <= EXP_ONE) begin
      w_norm_flag = 1'b1;
    end else if (w_sum_shl[MW-1]) begin
      // The shift that lands the leading one also finishes, so N equals the shift count.
      w_norm_out = {r_sign, w_exp_dec, w_sum_shl[SIGNI-1:0]};
    end else begin
      w_norm_done = 1'b0;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next = S_ALIGN;
      S_ALIGN: w_next = w_any_inf ? S_DONE : S_ADD;
      S_ADD:   w_next = S_NORM;
      S_NORM:  if (w_norm_done) w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_sign      <= 1'b0;
      r_eff_sub   <= 1'b0;
      r_exp       <= '0;
      r_sig_big   <= '0;
      r_sig_small <= '0;
      r_sum       <= '0;
      r_out       <= '0;
      r_flag      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_a <= para1;
          r_b <= {para2[DW-1] ^ op, para2[DW-2:0]};
        end
        S_ALIGN: begin
          if (w_any_inf) begin
            r_out  <= {w_inf_sign, EXP_MAX, {SIGNI{1'b0}}};
            r_flag <= 1'b1;
          end else begin
            r_sign      <= w_sign_big;
            r_eff_sub   <= (w_sign_big != w_sign_small);
            r_exp       <= w_exp_big;
            r_sig_big   <= w_sig_big;
            r_sig_small <= w_shifted;
          end
        end
        S_ADD: r_sum <= w_add;
        S_NORM: begin
          if (w_norm_done) begin
            r_out  <= w_norm_out;
            r_flag <= w_norm_flag;
          end else begin
            r_sum <= w_sum_shl;
            r_exp <= w_exp_dec;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready       = (r_state == S_IDLE);
  assign out_valid      = (r_state == S_DONE);
  assign out            = r_out;
  assign under_overflow = r_flag;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_fp_add_seq.sv
// Bench for fp_add_seq: directed corner cases plus randomized operations, scored by a queue-based
// monitor against a magnitude-level model of the truncating adder.
module tb_fp_add_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, op;
  logic [31:0] para1, para2, out;
  logic        out_valid, out_ready, under_overflow;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ready_mode = 2;  // 0 random, 1 forced low, 2 forced high
  bit seen = 1'b0;

  logic [32:0] exp_q[$];
  int          lat_q[$];
  int          acc_q[$];

  fp_add_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .para1(para1), .para2(para2), .op(op), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .under_overflow(under_overflow),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d", exp_q.size());
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void ref_add(input logic [31:0] a, input logic [31:0] b_in, input logic opv,
                                  output logic [31:0] r, output logic f, output int lat);
    logic [31:0] b, big, sml;
    int eb, es, d, p, sh, e;
    longint mb, ms, sum;
    b = b_in;
    b[31] = b_in[31] ^ opv;
    r = 32'h0; f = 1'b0; lat = 4;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
      r = {(a[30:23] == 8'hFF) ? a[31] : b[31], 8'hFF, 23'h0};
      f = 1'b1; lat = 2;
      return;
    end
    if (a[30:0] >= b[30:0]) begin big = a; sml = b; end
    else begin big = b; sml = a; end
    eb = int'(big[30:23]);
    es = int'(sml[30:23]);
    mb = (eb != 0) ? (longint'(1) << 23) + longint'(big[22:0]) : 0;
    ms = (es != 0) ? (longint'(1) << 23) + longint'(sml[22:0]) : 0;
    d  = eb - es;
    ms = (d >= 25) ? 0 : (ms >> d);
    sum = (big[31] == sml[31]) ? mb + ms : mb - ms;
    if (sum == 0) return;
    p = 0;
    for (int i = 0; i < 25; i++) if (sum[i]) p = i;
    if (p == 24) begin
      e = eb + 1;
      if (e >= 255) begin r = {big[31], 8'hFF, 23'h0}; f = 1'b1; end
      else r = {big[31], 8'(e), 23'(sum >> 1)};
      return;
    end
    sh = 23 - p;
    e  = eb - sh;
    if (e < 1) begin
      f = 1'b1; lat = 3 + eb;
      return;
    end
    r = {big[31], 8'(e), 23'(sum << sh)};
    lat = 3 + ((sh > 0) ? sh : 1);
  endfunction

  // ---------------- driver ----------------
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       out_ready = ($urandom_range(0, 3) != 0);
        1:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  task automatic issue_exp(input logic [31:0] a, input logic [31:0] b, input logic opv,
                           input logic [31:0] er, input logic ef, input int el);
    int w = 0;
    @(negedge clk);
    while (!in_ready && w < 500) begin @(negedge clk); w++; end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: in_ready low for %0d cycles, required 1", w);
      return;
    end
    para1 = a; para2 = b; op = opv; in_valid = 1'b1;
    exp_q.push_back({ef, er});
    lat_q.push_back(el);
    @(posedge clk);
    #1;
    acc_q.push_back(cyc);
    in_valid = 1'b0;
  endtask

  task automatic issue_rand(input logic [31:0] a, input logic [31:0] b, input logic opv);
    logic [31:0] r;
    logic f;
    int l;
    ref_add(a, b, opv, r, f, l);
    issue_exp(a, b, opv, r, f, l);
  endtask

  task automatic wait_drain();
    int w = 0;
    while ((exp_q.size() != 0 || !in_ready) && w < 3000) begin @(negedge clk); w++; end
    if (exp_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
      exp_q.delete(); lat_q.delete(); acc_q.delete();
    end
  endtask

  function automatic logic [31:0] rnd_op();
    int k;
    logic [7:0] e;
    k = $urandom_range(0, 19);
    if (k == 0)      e = 8'hFF;
    else if (k == 1) return {1'($urandom_range(0, 1)), 31'h0};
    else if (k == 2) e = 8'($urandom_range(250, 254));
    else if (k == 3) e = 8'($urandom_range(1, 4));
    else             e = 8'($urandom_range(1, 254));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  // ---------------- scoreboard monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen = 1'b0;
      end else begin
        if (out_valid && !seen) begin
          seen = 1'b1;
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_result: out_valid with out=%h, no operation outstanding", out);
          end else begin
            check("latency", 64'(cyc - acc_q[0] + 1), 64'(lat_q[0]));
          end
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() != 0) begin
            check("result_flag_out", {31'h0, under_overflow, out}, {31'h0, exp_q.pop_front()});
            void'(lat_q.pop_front());
            void'(acc_q.pop_front());
          end
          seen = 1'b0;
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] a, b, hold_out;
    logic        hold_flag;
    int          w;
    rst_n = 1'b0; in_valid = 1'b0; para1 = '0; para2 = '0; op = 1'b0;
    #3;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out", out, 0);
    check("reset_flag", under_overflow, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    issue_exp(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 4);
    issue_exp(32'h3FC00000, 32'h3F800000, 1'b0, 32'h40200000, 1'b0, 4);
    issue_exp(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 1'b0, 4);
    issue_exp(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, 4);
    issue_exp(32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 1'b0, 26);
    issue_exp(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 4);
    issue_exp(32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 1'b1, 2);
    issue_exp(32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 1'b1, 2);
    issue_exp(32'h7F800000, 32'hFF800000, 1'b0, 32'h7F800000, 1'b1, 2);
    issue_exp(32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 1'b1, 4);
    issue_exp(32'h40000000, 32'h00000000, 1'b0, 32'h40000000, 1'b0, 4);
    wait_drain();

    // Consumer stall: result must hold while new requests are refused.
    ready_mode = 1;
    @(negedge clk);
    issue_exp(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 1'b0, 4);
    w = 0;
    while (!out_valid && w < 50) begin @(negedge clk); w++; end
    check("stall_out_valid_seen", out_valid, 1);
    hold_out = out;
    hold_flag = under_overflow;
    for (int i = 0; i < 5; i++) begin
      para1 = $urandom; para2 = $urandom; in_valid = (i % 2 == 0);
      @(negedge clk);
      check("stall_out", out, hold_out);
      check("stall_flag", under_overflow, hold_flag);
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    ready_mode = 2;
    @(negedge clk);
    @(negedge clk);
    check("stall_consumed_valid", out_valid, 0);
    check("stall_consumed_in_ready", in_ready, 1);
    wait_drain();

    // Reset mid-NORM: the operation is discarded and outputs clear without a clock edge.
    @(negedge clk);
    para1 = 32'h3F800001; para2 = 32'h3F800000; op = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midreset_out_valid", out_valid, 0);
    check("midreset_in_ready", in_ready, 1);
    check("midreset_out", out, 0);
    check("midreset_flag", under_overflow, 0);
    repeat (3) begin
      @(negedge clk);
      check("midreset_hold_valid", out_valid, 0);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    issue_exp(32'h3FC00000, 32'h3F800000, 1'b0, 32'h40200000, 1'b0, 4);
    wait_drain();

    ready_mode = 0;
    for (int n = 0; n < 150; n++) begin
      a = rnd_op();
      b = rnd_op();
      if ($urandom_range(0, 1) == 1 && a[30:23] != 8'h00 && a[30:23] != 8'hFF) begin
        b = {1'($urandom_range(0, 1)), a[30:23], a[22:0] ^ (23'($urandom) >> $urandom_range(0, 22))};
        if ($urandom_range(0, 2) == 0 && a[30:23] > 8'd1) b[30:23] = a[30:23] - 8'd1;
      end
      issue_rand(a, b, 1'($urandom_range(0, 1)));
    end
    ready_mode = 2;
    wait_drain();
    check("queue_empty", 64'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_add_seq.md
FP_ADD_SEQ -- requirements
Module: fp_add_seq

Interface
REQ-001 SHALL have parameter SIGNI, default 23, meaning mantissa field width (hidden bit at index SIGNI).
REQ-002 SHALL have parameter EXPO_LENGTH, default 7, meaning exponent MSB index (8-bit exponent).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1, operands and op present.
REQ-006 SHALL have port in_ready, output, 1, block can accept an operation.
REQ-007 SHALL have port para1, input, 32, IEEE-754 single operand A.
REQ-008 SHALL have port para2, input, 32, IEEE-754 single operand B.
REQ-009 SHALL have port op, input, 1, 0 = A+B, 1 = A-B.
REQ-010 SHALL have port out_valid, output, 1, result present.
REQ-011 SHALL have port out_ready, input, 1, consumer takes result.
REQ-012 SHALL have port out, output, 32, IEEE-754 single result.
REQ-013 SHALL have port under_overflow, output, 1, result saturated to infinity or flushed to zero; valid with out_valid.

Function
REQ-014 SHALL implement FSM states IDLE, ALIGN, ADD, NORM, DONE.
REQ-015 SHALL assert in_ready only in IDLE; in_valid && in_ready on an edge captures para1, para2, op and moves to ALIGN.
REQ-016 SHALL, when op=1, invert captured para2 sign bit; subtraction then proceeds as signed addition.
REQ-017 SHALL form hidden bit = 1 if exponent != 0, else 0; exponent 0 operands are zero, no denormal support.
REQ-018 SHALL, in ALIGN, move directly to DONE with out = {sign of the exp-255 operand (A if both), 8'hFF, 23'h0} and under_overflow=1 when either exponent is 255.
REQ-019 SHALL, in ALIGN, order operands by {exponent, mantissa} magnitude, take result sign and exponent from the larger, and right-shift the smaller 24-bit significand by the exponent difference in one cycle; difference >= 25 gives zero; shifted-out bits are truncated.
REQ-020 SHALL, in ADD, form a 25-bit result: sum if signs equal, else larger minus smaller (never negative); then go to NORM.
REQ-021 SHALL, in NORM, on a zero result output +0 (32'h0), flag 0, in one NORM cycle.
REQ-022 SHALL, in NORM, on carry (bit 24) shift right 1 and increment exponent once, in one NORM cycle; exponent reaching 255 gives {sign, 8'hFF, 23'h0}, flag 1.
REQ-023 SHALL, in NORM, otherwise left-shift 1 bit and decrement exponent per cycle until bit 23 = 1; an already normalized result takes exactly one NORM cycle.
REQ-024 SHALL, if bit 23 is still 0 when the exponent would drop below 1, output +0 with flag 1.
REQ-025 SHALL give out = {sign, exponent, significand[22:0]}, truncated rounding only.
REQ-026 SHALL latency: out_valid rises 3+N edges after the accepting edge (N = NORM cycles), or 2 edges via the REQ-018 path.
REQ-027 SHALL, in DONE, hold out_valid=1 with out and under_overflow stable until out_valid && out_ready on an edge, then return to IDLE.
REQ-028 SHALL ignore in_valid outside IDLE; no operation queuing.

Reset
REQ-029 SHALL on rst_n=0, immediately and regardless of clk: state=IDLE, in_ready=1, out_valid=0, out=32'h0, under_overflow=0, internal registers cleared.
REQ-030 SHALL on reset mid-operation discard the operation with no result ever presented; first acceptance possible on the first edge after rst_n rises.

Verification
REQ-031 SHALL check 3F800000 + 3F800000, op=0 -> out=40000000, flag 0, out_valid 4 edges after accept.
REQ-032 SHALL check 3FC00000 + 3F800000 -> 40200000; 40400000 - 3F800000 (op=1) -> 40000000.
REQ-033 SHALL check 3F800000 - 3F800000 -> 00000000, flag 0; 3F800001 - 3F800000 -> 34000000 after 23 NORM cycles.
REQ-034 SHALL check 7F7FFFFF + 7F7FFFFF -> 7F800000, flag 1; 7F800000 + 3F800000 -> 7F800000, flag 1, 2-edge latency.
REQ-035 SHALL check out_ready held 0 for 5 cycles in DONE -> out and flag stable, in_ready 0, in_valid pulses ignored; result consumed on first out_ready edge.
REQ-036 SHALL check rst_n pulsed low during NORM -> outputs immediately at reset values, no out_valid, next operation correct.
